dmem_store_buffer: RTL and testbench
====================================

// Module: dmem_store_buffer
// PURPOSE
//  Posted-write buffer between the RISC-V core's data-memory store port and data memory.
//  - Captures core stores (MemWrite/DataAdr/WriteData) into a FIFO.
//  - Drains them to memory over a valid/ready handshake.
//  - Stalls the core only when full.
//  - Forwards buffered data to word-aligned loads, so loads never read stale memory.
// PARAMETERS
//  DEPTH   4   entries; power of two, >= 2
//  ADDR_W  32  address width
//  DATA_W  32  data width; full-word (sw) stores only
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  reset      in   1       synchronous, active-high
//  MemWrite   in   1       core store request this cycle
//  DataAdr    in   ADDR_W  store byte address; bits [1:0] ignored
//  WriteData  in   DATA_W  store data
//  stall      out  1       core must hold the store; = MemWrite && (count==DEPTH)
//  ld_addr    in   ADDR_W  core load address, combinational lookup
//  ld_hit     out  1       a buffered store matches ld_addr word
//  ld_data    out  DATA_W  data of youngest matching entry; 0 when !ld_hit
//  mem_we     out  1       drain valid: head entry presented to memory
//  mem_addr   out  ADDR_W  head entry address
//  mem_wdata  out  DATA_W  head entry data
//  mem_ready  in   1       memory accepts head this cycle
//  empty      out  1       count==0; used by fence/halt logic
// BEHAVIOUR
//  Reset values (cycle after reset high):
//  - count=0, head/tail pointers=0, mem_we=0, empty=1, stall=0, ld_hit=0.
//  - Buffered stores are discarded when reset is asserted mid-operation.
//  Enqueue:
//  - Occurs when MemWrite && count<DEPTH.
//  - Writes {DataAdr,WriteData} at tail; tail+1 mod DEPTH.
//  - When full, no bypass: stall=1 and nothing is written, even if mem_ready=1 that cycle.
//  Latency: a store enqueued at edge N is on mem_we/mem_addr/mem_wdata from cycle N+1.
//  - No empty-buffer bypass.
//  Drain:
//  - mem_we = (count!=0); mem_addr/mem_wdata = head entry.
//  - Pop on mem_we && mem_ready; head+1 mod DEPTH.
//  - While mem_we=1 && !mem_ready, head outputs hold stable.
//  Simultaneous enqueue + pop: count unchanged; both pointers advance.
//  - Legal at every occupancy except count==DEPTH (no enqueue) and count==0 (no pop).
//  Count and pointers:
//  - count is $clog2(DEPTH)+1 bits.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally.
//  - count never exceeds DEPTH or underflows.
//  Forwarding (combinational, no state):
//  - Compare ld_addr[ADDR_W-1:2] against every valid entry's addr[ADDR_W-1:2].
//  - Youngest (closest to tail) match wins.
//  - The store presented on MemWrite in the same cycle is not visible to ld_*.
//  - Forwarding covers entries being popped this cycle.
//  Ordering: memory sees stores in program order; duplicate addresses are not coalesced.
// STRUCTURE
//  Package dmem_pkg:
//  - typedef struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} sb_entry_t
//  - localparam SB_IDX_W = $clog2(DEPTH)
//  Sub-module sb_fwd_select:
//  - Combinational youngest-match priority selector.
//  - Inputs: entry array, valid mask, head index, ld_addr.
//  - Outputs: ld_hit, ld_data.
//  - The top holds the entry array, pointers, count and handshake.
// TESTING
//  1. Reset held 2 cycles -> mem_we=0, empty=1, stall=0, ld_hit=0.
//  2. Single store 100<-25, mem_ready=1 -> mem_we=1, mem_addr=100, mem_wdata=25 exactly one cycle later; empty=1 next.
//  3. mem_ready=0; stores 96<-7, 100<-25, 104<-1, 108<-2, 112<-3:
//     - stall=1 on fifth store.
//     - mem_addr stays 96.
//     - Raise mem_ready: drain order is 96,100,104,108, then 112 once accepted.
//  4. Buffer 100<-25 then 100<-26, ld_addr=102 -> ld_hit=1, ld_data=26; ld_addr=104 -> ld_hit=0, ld_data=0.
//  5. count==2 with enqueue + pop same cycle -> count stays 2; ten-store stream at mem_ready=1 wraps pointers, order preserved.
//  6. Reset asserted with 3 entries buffered -> next cycle mem_we=0, empty=1; no further memory writes.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory store buffer.
package dmem_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_IDX_W  = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_select.sv
// Youngest-match load forwarding selector over the store buffer entries.
module sb_fwd_select
  import dmem_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  sb_entry_t          entries [DEPTH],
  input  logic [DEPTH-1:0]   valid,
  input  logic [IDX_W-1:0]   head,
  input  logic [ADDR_W-1:0]  ld_addr,
  output logic               ld_hit,
  output logic [DATA_W-1:0]  ld_data
);

  logic [IDX_W-1:0] idx;
  logic             unused_ld_lsb;

  assign unused_ld_lsb = ^ld_addr[1:0];

  // Walk oldest to youngest so the last match written is the youngest one.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + IDX_W'(k);
      if (valid[idx] && (entries[idx].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write FIFO between the core store port and data memory, with load forwarding.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              stall,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              empty
);

  localparam int IDX_W = $clog2(DEPTH);

  sb_entry_t        entries [DEPTH];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;
  logic [DEPTH-1:0] valid;
  logic [IDX_W-1:0] offs;
  logic             full;
  logic             enq;
  logic             pop;

  assign full      = (count == (IDX_W+1)'(DEPTH));
  assign enq       = MemWrite && !full;
  assign pop       = mem_we && mem_ready;
  assign stall     = MemWrite && full;
  assign mem_we    = (count != '0);
  assign empty     = (count == '0);
  assign mem_addr  = entries[head].addr;
  assign mem_wdata = entries[head].data;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity comes solely from head/count.
  always_ff @(posedge clk) begin
    if (enq) entries[tail] <= '{addr: DataAdr, data: WriteData};
  end

  always_comb begin
    valid = '0;
    offs  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs     = IDX_W'(i) - head;
      valid[i] = ({1'b0, offs} < count);
    end
  end

  sb_fwd_select #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_fwd (
    .entries (entries),
    .valid   (valid),
    .head    (head),
    .ld_addr (ld_addr),
    .ld_hit  (ld_hit),
    .ld_data (ld_data)
  );

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer.
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        stall;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .stall     (stall),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .empty     (empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    step();
    MemWrite  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    ld_addr = '0; mem_ready = 1'b0;

    // 1. reset held two cycles
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_empty",  32'(empty),  1);
    check("rst_stall",  32'(stall),  0);
    check("rst_ld_hit", 32'(ld_hit), 0);

    // 2. single store, one-cycle latency, then accepted
    mem_ready = 1'b1;
    MemWrite = 1'b1; DataAdr = 100; WriteData = 25;
    #1;
    check("t2_no_bypass", 32'(mem_we), 0);
    step();
    MemWrite = 1'b0;
    check("t2_mem_we",    32'(mem_we), 1);
    check("t2_mem_addr",  mem_addr,    100);
    check("t2_mem_wdata", mem_wdata,   25);
    step();
    check("t2_empty_after", 32'(empty), 1);

    // 3. fill with memory stalled, fifth store stalls, then drain in order
    mem_ready = 1'b0;
    store(96, 7); store(100, 25); store(104, 1); store(108, 2);
    MemWrite = 1'b1; DataAdr = 112; WriteData = 3;
    #1;
    check("t3_stall_full", 32'(stall), 1);
    check("t3_head_96",    mem_addr,   96);
    step();
    check("t3_hold_addr",  mem_addr,   96);
    check("t3_hold_data",  mem_wdata,  7);
    mem_ready = 1'b1;
    #1;
    check("t3_stall_ready", 32'(stall), 1);
    step();
    check("t3_drain_100", mem_addr, 100);
    check("t3_unstall",   32'(stall), 0);
    step();
    MemWrite = 1'b0;
    check("t3_drain_104", mem_addr, 104);
    step();
    check("t3_drain_108", mem_addr, 108);
    step();
    check("t3_drain_112", mem_addr, 112);
    check("t3_data_112",  mem_wdata, 3);
    step();
    check("t3_empty", 32'(empty), 1);

    // 4. forwarding: youngest match, word granularity, same-cycle store invisible
    mem_ready = 1'b0;
    store(100, 25); store(100, 26);
    ld_addr = 102;
    #1;
    check("t4_hit",     32'(ld_hit), 1);
    check("t4_data",    ld_data,     26);
    ld_addr = 104;
    #1;
    check("t4_miss",      32'(ld_hit), 0);
    check("t4_miss_data", ld_data,     0);
    MemWrite = 1'b1; DataAdr = 104; WriteData = 9;
    #1;
    check("t4_same_cycle", 32'(ld_hit), 0);
    MemWrite = 1'b0;
    mem_ready = 1'b1; ld_addr = 100;
    #1;
    check("t4_pop_hit",  32'(ld_hit), 1);
    check("t4_pop_data", ld_data,     26);
    step();
    check("t4_after_pop", ld_data, 26);
    step();
    check("t4_gone", 32'(ld_hit), 0);
    check("t4_empty", 32'(empty), 1);

    // 5. enqueue + pop at count==2 keeps count at 2
    mem_ready = 1'b0;
    store(200, 1); store(204, 2);
    mem_ready = 1'b1;
    store(208, 3);
    check("t5_head_204", mem_addr, 204);
    mem_ready = 1'b0;
    store(212, 4);
    MemWrite = 1'b1; DataAdr = 216; WriteData = 5;
    #1;
    check("t5_not_full", 32'(stall), 0);
    step();
    MemWrite = 1'b1; DataAdr = 220; WriteData = 6;
    #1;
    check("t5_full_at_4", 32'(stall), 1);
    MemWrite = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("t5_order_204", mem_addr, 204);
    step();
    check("t5_order_208", mem_addr, 208);
    step();
    check("t5_order_212", mem_addr, 212);
    step();
    check("t5_order_216", mem_addr, 216);
    step();
    check("t5_drained", 32'(empty), 1);

    // ten-store stream with memory always ready: pointers wrap
    for (int i = 0; i < 10; i++) begin
      MemWrite = 1'b1; DataAdr = 32'(300 + 4*i); WriteData = 32'(50 + i);
      #1;
      check("t5_stream_stall", 32'(stall), 0);
      step();
      check("t5_stream_addr", mem_addr,  32'(300 + 4*i));
      check("t5_stream_data", mem_wdata, 32'(50 + i));
    end
    MemWrite = 1'b0;
    step();
    check("t5_stream_empty", 32'(empty), 1);

    // 6. reset with three entries buffered discards them
    mem_ready = 1'b0;
    store(400, 11); store(404, 12); store(408, 13);
    check("t6_pending", 32'(mem_we), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_mem_we", 32'(mem_we), 0);
    check("t6_empty",  32'(empty),  1);
    mem_ready = 1'b1; ld_addr = 404;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_write", 32'(mem_we), 0);
    end
    check("t6_no_fwd", 32'(ld_hit), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
